// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 round scheduler constants and state encoding
package aes_pkg;

  // Number of AES-256 rounds; the round counter spans 0..AES_NR.
  localparam int AES_NR = 14;

  // Plaintext/ciphertext block width.
  localparam int BLK_W = 128;

  // Width of the round number / round-key index.
  localparam int RND_W = 4;

  // Scheduler states: waiting for a block, stepping rounds, holding the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/aes256_round_sched.sv
// rtl/aes256_round_sched.sv - sequences one AES-256 block through an external round datapath
module aes256_round_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             key_valid,
  output logic [RND_W-1:0] key_idx,
  output logic [BLK_W-1:0] dp_text,
  output logic [RND_W-1:0] dp_round,
  output logic             dp_en,
  input  logic [BLK_W-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  localparam logic [RND_W-1:0] LP_LAST = RND_W'(NR);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [RND_W-1:0] r_round;
  logic [BLK_W-1:0] r_dp_text;
  logic [BLK_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_captured;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_key_take;
  logic             w_last;
  logic             w_release;
  logic             w_dp_en;

  // in_ready is registered, so only IDLE (one cycle after entry) can accept.
  assign w_accept   = in_valid & r_in_ready;
  assign w_key_take = (r_state == ST_RUN) & key_valid;
  assign w_last     = w_key_take & (r_round == LP_LAST);
  assign w_release  = (r_state == ST_DONE) & r_out_valid & out_ready;

  // Current FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath enable; a round only advances when its key is present.
  always_comb begin
    w_state_nxt = r_state;
    w_dp_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_dp_en = key_valid;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Ready flop: stays low in reset, then follows "next state is IDLE" so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // Block capture on accept and round counting; the counter saturates at the final round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_text <= '0;
      r_round   <= '0;
    end else if (w_accept) begin
      r_dp_text <= in_data;
      r_round   <= '0;
    end else if (w_key_take && !w_last) begin
      r_round <= r_round + RND_W'(1);
    end
  end

  // Result handling in DONE: capture dp_result, then raise out_valid, then wait for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_captured  <= 1'b0;
    end else if (w_accept) begin
      r_captured <= 1'b0;
    end else if (r_state == ST_DONE) begin
      if (!r_captured) begin
        r_out_data <= dp_result;
        r_captured <= 1'b1;
      end else if (!r_out_valid) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign key_idx   = r_round;
  assign dp_round  = r_round;
  assign dp_text   = r_dp_text;
  assign dp_en     = w_dp_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/aes256_round_sched.md
AES256_ROUND_SCHED -- requirements
Module: aes256_round_sched

Interface
REQ-001 SHALL have parameter NR, default 14, meaning the number of AES-256 rounds; the round counter spans 0..NR.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, plaintext block offered.
REQ-005 SHALL have port in_ready, output, 1, scheduler can accept a block.
REQ-006 SHALL have port in_data, input, 128, plaintext block.
REQ-007 SHALL have port key_valid, input, 1, round key for key_idx is present this cycle.
REQ-008 SHALL have port key_idx, output, 4, round-key index requested (equals round).
REQ-009 SHALL have port dp_text, output, 128, captured block driven to the round datapath.
REQ-010 SHALL have port dp_round, output, 4, round number driven to the datapath.
REQ-011 SHALL have port dp_en, output, 1, datapath state-register update enable.
REQ-012 SHALL have port dp_result, input, 128, registered datapath output.
REQ-013 SHALL have port out_valid, output, 1, ciphertext available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the ciphertext.
REQ-015 SHALL have port out_data, output, 128, ciphertext block.
REQ-016 SHALL have port busy, output, 1, a block is in flight (RUN or DONE).

Function
REQ-017 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 IDLE: in_ready=1; a transfer occurs when in_valid&in_ready; on transfer, in_data SHALL be latched into dp_text, round SHALL be cleared to 0, and the FSM SHALL enter RUN.
REQ-019 in_ready SHALL be 0 in RUN and DONE; the block accepts one block in flight only.
REQ-020 RUN: dp_en = key_valid; key_idx = dp_round = round.
REQ-021 RUN: on a cycle with key_valid=1, round SHALL increment by 1; with key_valid=0, round SHALL hold and dp_en SHALL be 0 (stall).
REQ-022 Round semantics on the datapath: round 0 = AddRoundKey on dp_text; rounds 1..NR-1 = full rounds; round NR = final round without MixColumns.
REQ-023 On the enabled cycle for round NR, the FSM SHALL enter DONE the next cycle and capture dp_result into out_data on the first DONE cycle.
REQ-024 out_valid SHALL assert one cycle after the capture.
REQ-025 With no stalls, latency from the accept edge to out_valid=1 SHALL be NR+3 cycles (17 for NR=14).
REQ-026 DONE: out_valid and out_data SHALL hold stable until out_ready=1; on that cycle the FSM SHALL return to IDLE.
REQ-027 A new block SHALL be accepted no earlier than the cycle after the out_valid&out_ready handshake, with no combinational path from out_ready to in_ready.
REQ-028 round SHALL never exceed NR.
REQ-029 key_valid SHALL be ignored outside RUN.
REQ-030 dp_en SHALL be 0 outside RUN.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, round=0, dp_text=0, out_data=0, out_valid=0, dp_en=0, in_ready=0 while asserted, and in_ready=1 from the first clock after deassertion.
REQ-033 Reset asserted mid-RUN or mid-DONE SHALL discard the in-flight block, with no out_valid pulse after release.

Structure
REQ-034 NR, the state encoding, and the 128-bit block width SHALL reside in shared package aes_pkg.
REQ-035 No sub-module SHALL be used; the datapath is instantiated alongside by the integrating top level.

Verification
REQ-036 Single block, key_valid tied 1, in_data=00112233_44556677_8899aabb_ccddeeff, datapath with FIPS-197 AES-256 key 000102..1f -> out_valid at accept+17, out_data=8ea2b7ca_516745bf_eafc4990_4b496089.
REQ-037 key_valid low for 3 cycles at round 5 -> round holds at 5, dp_en=0 for those cycles, out_valid at accept+20, same ciphertext.
REQ-038 out_ready held 0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-039 Back-to-back: in_valid held 1 with two blocks and out_ready=1 -> second accept one cycle after the first out handshake; both ciphertexts correct and in order.
REQ-040 rst_n pulsed low at round 7 -> outputs zero immediately, no out_valid; a subsequent block completes correctly.
REQ-041 in_valid asserted during RUN -> in_ready=0, in_data changes ignored, dp_text unchanged.
